// File: rtl/mdu_if.sv
// Request/response bundle between the execute stage and the multiply/divide unit.
// The master issues ops and selects the read port; the slave owns HI/LO.
interface mdu_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic        readSel;
    logic [31:0] readData;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, srcA, srcB, readSel,
        input  readData, busy, hi, lo
    );

    modport slave (
        input  start, op, srcA, srcB, readSel,
        output readData, busy, hi, lo
    );
endinterface

// File: rtl/mdu.sv
// Multiply/divide unit holding the architectural HI/LO registers. Mult/div latch their
// operands and occupy a fixed busy window; mthi/mtlo write in a single cycle.
module mdu #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input logic  clk,
    input logic  reset,
    mdu_if.slave bus
);
    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntWidth  = $clog2(MaxCycles + 1);

    localparam logic [2:0] OpMult  = 3'd0;
    localparam logic [2:0] OpMultu = 3'd1;
    localparam logic [2:0] OpDiv   = 3'd2;
    localparam logic [2:0] OpDivu  = 3'd3;
    localparam logic [2:0] OpMthi  = 3'd4;
    localparam logic [2:0] OpMtlo  = 3'd5;

    typedef enum logic {StIdle, StRun} stateT;

    stateT               stateQ, stateD;
    logic [CntWidth-1:0] countQ, countD;
    logic [31:0]         opAQ, opAD;
    logic [31:0]         opBQ, opBD;
    logic [2:0]          kindQ, kindD;
    logic [31:0]         hiQ, hiD;
    logic [31:0]         loQ, loD;

    logic accept;
    assign accept = bus.start && (stateQ == StIdle) && (bus.op <= OpMtlo);

    // Products computed from the latched operands only.
    logic [63:0] prodSigned, prodUnsigned;
    assign prodSigned   = {{32{opAQ[31]}}, opAQ} * {{32{opBQ[31]}}, opBQ};
    assign prodUnsigned = {32'd0, opAQ} * {32'd0, opBQ};

    // Signed divide via magnitudes; the overflow case falls out as 0x80000000 / 1.
    logic        negA, negB;
    logic [31:0] magA, magB, magBSafe;
    logic [31:0] quotU, remU, quot, rem;
    assign negA     = (kindQ == OpDiv) && opAQ[31];
    assign negB     = (kindQ == OpDiv) && opBQ[31];
    assign magA     = negA ? (~opAQ + 32'd1) : opAQ;
    assign magB     = negB ? (~opBQ + 32'd1) : opBQ;
    assign magBSafe = (magB == 32'd0) ? 32'd1 : magB;
    assign quotU    = magA / magBSafe;
    assign remU     = magA % magBSafe;
    assign quot     = (negA ^ negB) ? (~quotU + 32'd1) : quotU;
    assign rem      = negA ? (~remU + 32'd1) : remU;

    always_comb begin
        stateD = stateQ;
        countD = countQ;
        opAD   = opAQ;
        opBD   = opBQ;
        kindD  = kindQ;
        hiD    = hiQ;
        loD    = loQ;
        unique case (stateQ)
            StIdle: begin
                if (accept) begin
                    case (bus.op)
                        OpMthi: hiD = bus.srcA;
                        OpMtlo: loD = bus.srcA;
                        default: begin
                            opAD   = bus.srcA;
                            opBD   = bus.srcB;
                            kindD  = bus.op;
                            stateD = StRun;
                            countD = ((bus.op == OpMult) || (bus.op == OpMultu)) ?
                                     CntWidth'(MULT_CYCLES) : CntWidth'(DIV_CYCLES);
                        end
                    endcase
                end
            end
            StRun: begin
                if (countQ == CntWidth'(1)) begin
                    stateD = StIdle;
                    countD = '0;
                    case (kindQ)
                        OpMult:  {hiD, loD} = prodSigned;
                        OpMultu: {hiD, loD} = prodUnsigned;
                        OpDiv, OpDivu: begin
                            // A zero divisor burns the busy window but leaves HI/LO alone.
                            if (opBQ != 32'd0) begin
                                loD = quot;
                                hiD = rem;
                            end
                        end
                        default: ;
                    endcase
                end else begin
                    countD = countQ - CntWidth'(1);
                end
            end
            default: stateD = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateQ <= StIdle;
            countQ <= '0;
            opAQ   <= '0;
            opBQ   <= '0;
            kindQ  <= '0;
            hiQ    <= '0;
            loQ    <= '0;
        end else begin
            stateQ <= stateD;
            countQ <= countD;
            opAQ   <= opAD;
            opBQ   <= opBD;
            kindQ  <= kindD;
            hiQ    <= hiD;
            loQ    <= loD;
        end
    end

    assign bus.busy     = (stateQ == StRun);
    assign bus.hi       = hiQ;
    assign bus.lo       = loQ;
    assign bus.readData = bus.readSel ? hiQ : loQ;
endmodule

// File: tb/tb_mdu.sv
// Bench for mdu: directed cases from the block's test plan followed by random ops,
// all checked against an arithmetic model of HI/LO.
module tb_mdu;
    localparam int unsigned MultCycles = 5;
    localparam int unsigned DivCycles  = 10;

    logic clk;
    logic reset;
    mdu_if bus ();

    mdu #(
        .MULT_CYCLES(MultCycles),
        .DIV_CYCLES (DivCycles)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int          checkCount = 0;
    int          passCount  = 0;
    int          failCount  = 0;
    logic [31:0] hiM, loM;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [2:0] op, input logic [31:0] a,
                                  input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd0: begin p = 64'(sa * sb); hiM = p[63:32]; loM = p[31:0]; end
            3'd1: begin p = {32'd0, a} * {32'd0, b}; hiM = p[63:32]; loM = p[31:0]; end
            3'd2: if (b != 0) begin q = sa / sb; r = sa % sb; loM = q[31:0]; hiM = r[31:0]; end
            3'd3: if (b != 0) begin loM = a / b; hiM = a % b; end
            3'd4: hiM = a;
            3'd5: loM = a;
            default: ;
        endcase
    endfunction

    function automatic int busyCycles(input logic [2:0] op);
        if (op <= 3'd1) return MultCycles;
        if (op <= 3'd3) return DivCycles;
        return 0;
    endfunction

    // Called at a negedge; returns at a negedge after the op (and its busy window) is over.
    task automatic runOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] injOp, input string tag);
        int          n;
        int          injAt;
        logic [31:0] oldHi, oldLo;
        n     = busyCycles(op);
        oldHi = hiM;
        oldLo = loM;
        bus.start = 1'b1;
        bus.op    = op;
        bus.srcA  = a;
        bus.srcB  = b;
        @(negedge clk);
        bus.start = 1'b0;
        model(op, a, b);
        if (n > 0) begin
            injAt = $urandom_range(0, n - 1);
            for (int i = 0; i < n; i++) begin
                check({tag, " busy"}, 32'(bus.busy), 32'd1);
                bus.readSel = 1'($urandom_range(0, 1));
                #1;
                check({tag, " readOld"}, bus.readData, bus.readSel ? oldHi : oldLo);
                // Operands may change freely; a start while busy must be ignored.
                bus.srcA  = $urandom;
                bus.srcB  = $urandom;
                bus.op    = injOp;
                bus.start = (i == injAt);
                @(negedge clk);
            end
            bus.start = 1'b0;
        end
        check({tag, " idle"}, 32'(bus.busy), 32'd0);
        check({tag, " hi"}, bus.hi, hiM);
        check({tag, " lo"}, bus.lo, loM);
        bus.readSel = 1'b1;
        #1 check({tag, " readHi"}, bus.readData, hiM);
        bus.readSel = 1'b0;
        #1 check({tag, " readLo"}, bus.readData, loM);
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        clk         = 1'b0;
        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.op      = 3'd0;
        bus.srcA    = 32'd0;
        bus.srcB    = 32'd0;
        bus.readSel = 1'b0;
        hiM         = 32'd0;
        loM         = 32'd0;

        #3 reset = 1'b0;
        #1;
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset hi", bus.hi, 32'd0);
        check("reset lo", bus.lo, 32'd0);
        check("reset readData", bus.readData, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        runOp(3'd0, 32'hFFFF_FFFD, 32'd5, 3'd5, "mult");
        check("mult hi const", bus.hi, 32'hFFFF_FFFF);
        check("mult lo const", bus.lo, 32'hFFFF_FFF1);

        runOp(3'd1, 32'hFFFF_FFFF, 32'd2, 3'd4, "multu");
        check("multu hi const", bus.hi, 32'h0000_0001);
        check("multu lo const", bus.lo, 32'hFFFF_FFFE);

        runOp(3'd2, 32'hFFFF_FFF9, 32'd2, 3'd0, "div");
        check("div lo const", bus.lo, 32'hFFFF_FFFD);
        check("div hi const", bus.hi, 32'hFFFF_FFFF);

        runOp(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 3'd5, "divovf");
        check("divovf lo const", bus.lo, 32'h8000_0000);
        check("divovf hi const", bus.hi, 32'h0000_0000);

        runOp(3'd3, 32'd7, 32'd0, 3'd4, "divu0");
        check("divu0 lo const", bus.lo, 32'h8000_0000);
        check("divu0 hi const", bus.hi, 32'h0000_0000);

        runOp(3'd4, 32'h1234_5678, 32'd0, 3'd0, "mthi");
        check("mthi hi const", bus.hi, 32'h1234_5678);

        runOp(3'd0, 32'd3, 32'd4, 3'd5, "multIgnore");
        check("multIgnore lo const", bus.lo, 32'd12);

        // Reset four cycles into a divide, released before its completion edge.
        bus.start = 1'b1;
        bus.op    = 3'd2;
        bus.srcA  = 32'd100;
        bus.srcB  = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("midReset busy", 32'(bus.busy), 32'd0);
        check("midReset hi", bus.hi, 32'd0);
        check("midReset lo", bus.lo, 32'd0);
        hiM = 32'd0;
        loM = 32'd0;
        @(negedge clk);
        reset = 1'b1;
        repeat (8) @(negedge clk);
        check("postReset busy", 32'(bus.busy), 32'd0);
        check("postReset hi", bus.hi, 32'd0);
        check("postReset lo", bus.lo, 32'd0);
        runOp(3'd0, 32'd6, 32'd7, 3'd2, "mult6x7");
        check("mult6x7 lo const", bus.lo, 32'd42);
        check("mult6x7 hi const", bus.hi, 32'd0);

        runOp(3'd6, 32'hDEAD_BEEF, 32'd1, 3'd0, "nop6");
        runOp(3'd7, 32'hCAFE_F00D, 32'd1, 3'd0, "nop7");

        for (int k = 0; k < 40; k++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 9));
                default: ;
            endcase
            runOp(rop, ra, rb, 3'($urandom_range(0, 7)), "rand");
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
